// File: rtl/win_screen_addr_gen.sv
// Win-screen pixel address generator: maps VGA counters onto one of N_PLAYERS stacked,
// upscaled win images in ROM, with a frame-synchronous flash/hold sequence and blanking.
module win_screen_addr_gen #(
    parameter int unsigned IMG_W         = 160,
    parameter int unsigned IMG_H         = 120,
    parameter int unsigned SCALE_SHIFT   = 2,
    parameter int unsigned N_PLAYERS     = 3,
    parameter int unsigned ADDR_W        = 17,
    parameter int unsigned FLASH_FRAMES  = 30,
    parameter int unsigned FLASH_TOGGLES = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           h_cnt,
    input  logic [9:0]           v_cnt,
    input  logic                 valid,
    input  logic                 frame_tick,
    input  logic [N_PLAYERS-1:0] player,
    output logic [ADDR_W-1:0]    pixel_addr,
    output logic                 pix_en,
    output logic [1:0]           state_dbg
);
    localparam int unsigned FCNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int unsigned TOG_W  = $clog2(FLASH_TOGGLES + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFlash = 2'd1,
        StHold  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic [TOG_W-1:0]       tog_q, tog_d;
    logic                   vis_q, vis_d;
    logic [N_PLAYERS-1:0]   player_q;
    logic [N_PLAYERS-1:0]   cur_q, cur_d;
    logic                   p_valid;
    logic [ADDR_W-1:0]      base;

    logic [9:0]             x_q, y_q;
    logic                   in_win_q;
    logic [ADDR_W-1:0]      row_q;
    logic [ADDR_W-1:0]      pixel_addr_q, pixel_addr_d;
    logic                   pix_en_q, pix_en_d;

    // Each image base is a per-bit constant, so the decode is a mux rather than a multiply.
    always_comb begin
        p_valid = $onehot(player_q);
        base    = '0;
        for (int i = 0; i < int'(N_PLAYERS); i++) begin
            if (player_q[i]) begin
                base = ADDR_W'(i * IMG_W * IMG_H);
            end
        end
        if (!p_valid) begin
            base = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        tog_d   = tog_q;
        vis_d   = vis_q;
        cur_d   = cur_q;
        if (!p_valid) begin
            state_d = StIdle;
        end else if (state_q == StIdle || player_q != cur_q) begin
            // Entry or winner change: restart flashing; a coincident frame_tick is dropped.
            state_d = StFlash;
            fcnt_d  = '0;
            tog_d   = '0;
            vis_d   = 1'b1;
            cur_d   = player_q;
        end else if (state_q == StHold) begin
            vis_d = 1'b1;
        end else if (frame_tick) begin
            if (fcnt_q == FCNT_W'(FLASH_FRAMES - 1)) begin
                fcnt_d = '0;
                vis_d  = ~vis_q;
                tog_d  = tog_q + TOG_W'(1);
                if (tog_q + TOG_W'(1) == TOG_W'(FLASH_TOGGLES)) begin
                    state_d = StHold;
                    vis_d   = 1'b1;
                end
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            fcnt_q   <= '0;
            tog_q    <= '0;
            vis_q    <= 1'b1;
            player_q <= '0;
            cur_q    <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            tog_q    <= tog_d;
            vis_q    <= vis_d;
            player_q <= player;
            cur_q    <= cur_d;
        end
    end

    always_comb begin
        pixel_addr_d = in_win_q ? (base + row_q + ADDR_W'(x_q)) : '0;
        pix_en_d     = in_win_q && vis_q && (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            in_win_q     <= 1'b0;
            row_q        <= '0;
            pixel_addr_q <= '0;
            pix_en_q     <= 1'b0;
        end else begin
            x_q          <= h_cnt >> SCALE_SHIFT;
            y_q          <= v_cnt >> SCALE_SHIFT;
            in_win_q     <= valid && (32'(h_cnt >> SCALE_SHIFT) < IMG_W)
                                  && (32'(v_cnt >> SCALE_SHIFT) < IMG_H);
            row_q        <= ADDR_W'(v_cnt >> SCALE_SHIFT) * ADDR_W'(IMG_W);
            pixel_addr_q <= pixel_addr_d;
            pix_en_q     <= pix_en_d;
        end
    end

    assign pixel_addr = pixel_addr_q;
    assign pix_en     = pix_en_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/win_screen_addr_gen.md
Name: win_screen_addr_gen

Overview:
- Parametrised, pipelined successor to the win-screen pixel address generator.
- Maps VGA counters onto one of N_PLAYERS stacked win images in block-ROM, upscaled by 2^SCALE_SHIFT.
- Adds a frame-synchronous flash/hold sequence and out-of-window blanking.
- Sits between the VGA timing controller and the win-image ROM; the pixel mux uses pix_en to select ROM data or black.

Parameters:
- IMG_W, 160: stored image width in pixels.
- IMG_H, 120: stored image height in pixels.
- SCALE_SHIFT, 2: log2 of the upscale factor; screen window is (IMG_W<<SCALE_SHIFT) x (IMG_H<<SCALE_SHIFT).
- N_PLAYERS, 3: number of images and width of the player one-hot input.
- ADDR_W, 17: pixel_addr width; must hold N_PLAYERS*IMG_W*IMG_H-1.
- FLASH_FRAMES, 30: frame_tick pulses per flash half-period.
- FLASH_TOGGLES, 6: visibility toggles before entering HOLD.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous, active-high reset.
- h_cnt  in  10  horizontal pixel counter.
- v_cnt  in  10  vertical line counter.
- valid  in  1  active-video flag from VGA controller.
- frame_tick  in  1  one-cycle pulse per frame (start of vblank).
- player  in  N_PLAYERS  one-hot winner select; all-zero = no winner.
- pixel_addr  out  ADDR_W  registered ROM address.
- pix_en  out  1  registered; 1 = show ROM pixel, 0 = black.
- state_dbg  out  2  current FSM state (IDLE=0, FLASH=1, HOLD=2).

Behaviour:
- Reset: pixel_addr=0, pix_en=0, state=IDLE; flash counters, toggle count and player register cleared; visible=1.
- Player decode:
  - player is registered each cycle.
  - Valid = exactly one bit set; idx = bit position; base = idx*IMG_W*IMG_H (constant-folded, no runtime multiplier on idx).
  - Zero or multiple bits set = invalid.
- FSM (advances only on frame_tick, except the restart rules below):
  - IDLE: on a valid player -> FLASH; clear frame counter and toggles; visible=1.
  - FLASH: each frame_tick increments the frame counter. When it reaches FLASH_FRAMES-1 on a tick: counter->0, visible inverts, toggles++. When toggles reaches FLASH_TOGGLES: -> HOLD with visible=1.
  - HOLD: visible=1 permanently.
  - Any state: player invalid -> IDLE next cycle.
  - FLASH/HOLD: registered valid player changes to a different valid one -> restart FLASH next cycle.
  - Player change and frame_tick in the same cycle: the restart wins and the tick is discarded.
- Address pipeline (latency exactly 2 clk from h_cnt/v_cnt/valid to outputs):
  - Stage 1 registers: x=h_cnt>>SCALE_SHIFT, y=v_cnt>>SCALE_SHIFT, in_win=valid && x<IMG_W && y<IMG_H, and row=y*IMG_W.
  - Stage 2 registers: pixel_addr = in_win ? base+row+x : 0; pix_en = in_win && visible && state!=IDLE.
- Arithmetic: unsigned; all sums computed at ADDR_W bits with no truncation for legal parameters.
- Window edges: h_cnt = (IMG_W<<SCALE_SHIFT)-1 is inside; h_cnt = IMG_W<<SCALE_SHIFT is outside. The same rule applies to v_cnt.
- Reset mid-sequence: synchronous reset overrides everything; both pipeline stages are flushed to 0.

Test Plan:
- Reset hold, then release with player=0, valid=1 -> pix_en=0 and state_dbg=0 for all h/v.
- player=3'b010, h_cnt=8, v_cnt=4, valid=1 -> 2 cycles later pixel_addr=19200+160*1+2=19362, pix_en=1.
- player=3'b100, h_cnt=639, v_cnt=479 -> pixel_addr=38400+119*160+159=57599. At h_cnt=640 -> pixel_addr=0, pix_en=0.
- player=3'b001 held, pulse frame_tick 30 times -> visible off after tick 30, on after tick 60. After 180 ticks -> state_dbg=2 with pix_en steady 1.
- During FLASH, switch player to 3'b100 in the same cycle as a frame_tick -> state restarts FLASH, frame counter=0, base=38400.
- player=3'b011 (invalid) mid-HOLD -> IDLE next cycle, pix_en=0. Assert rst mid-FLASH -> all outputs 0 on the following edge.
